// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles a little-endian byte stream into
// 32-bit words and writes them to consecutive addresses while stalling the core.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for start
  // RECV  | accepting stream bytes into the assembly register
  // WRITE | one-cycle write of the assembled word
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_t              state_q;
  logic [ADDR_W:0]     cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          idx_q;
  logic [2:0][7:0]     shift_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_waddr_q;
  logic [31:0]         mem_wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q <= '0;
            idx_q  <= '0;
            err_q  <= (word_count > DEPTH_W);
            cnt_q  <= (word_count > DEPTH_W) ? DEPTH_W : word_count;
            if (word_count == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RECV;
              busy_q  <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_valid) begin
            idx_q <= idx_q + 2'd1;
            // The fourth byte goes straight into the write data rather than the shift register
            if (idx_q == 2'd3) begin
              state_q     <= WRITE;
              mem_we_q    <= 1'b1;
              mem_waddr_q <= addr_q;
              mem_wdata_q <= {byte_data, shift_q[2], shift_q[1], shift_q[0]};
            end else begin
              shift_q[idx_q] <= byte_data;
            end
          end
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          // Compare one bit wider so a full 2**ADDR_W load ends without wrapping
          if (({1'b0, addr_q} + ONE_W) == cnt_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RECV;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready = (state_q == RECV);
  assign cpu_hold   = (state_q == RECV) || (state_q == WRITE);
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the instruction memory before the core runs. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory's write port. While loading, it holds the core in stall.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words in instruction memory
- ADDR_W, 6, word-address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a load; sampled only in IDLE
- word_count  in  ADDR_W+1  number of words to load; latched when start is accepted
- byte_valid  in  1  byte_data holds a valid byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction-memory write enable, one cycle per word
- mem_waddr  out  ADDR_W  word address being written
- mem_wdata  out  32  assembled instruction word
- busy  out  1  high from start acceptance until done
- cpu_hold  out  1  stall request to the core; equal to busy
- done  out  1  one-cycle pulse when the load completes
- err  out  1  sticky; set when word_count > DEPTH; cleared by the next accepted start

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 latches cnt = min(word_count, DEPTH), clears addr, byte index and err.
  - Sets err if word_count > DEPTH.
  - Goes to DONE if cnt==0; otherwise goes to RECV.
- RECV:
  - byte_ready=1. A byte is accepted on a clock edge where byte_valid && byte_ready.
  - Byte index k (0..3) goes into shift[8k+7:8k], so the first byte is the LSB.
  - After the 4th accepted byte: go to WRITE and reset the byte index.
- WRITE:
  - byte_ready=0, mem_we=1, mem_waddr=addr, mem_wdata=assembled word, for exactly one cycle.
  - Then addr increments.
  - If addr+1 == cnt, go to DONE; otherwise go back to RECV.
- DONE: done=1 for one cycle, busy drops, next state IDLE.
- start is ignored in every state except IDLE.
- byte_valid is ignored outside RECV; no bytes are consumed there.
- Arithmetic: addr is ADDR_W bits. The completion compare is done at ADDR_W+1 bits, so DEPTH=2**ADDR_W completes without wrap.
- Reset:
  - Any state goes to IDLE.
  - Output reset values: byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, cpu_hold=0, done=0, err=0.
  - Words already written stay in memory; a partially assembled word is discarded.

## Timing
- All outputs are registered, except byte_ready and cpu_hold, which decode directly from state.
- Cycle after start accepted: busy=1, cpu_hold=1, byte_ready=1.
  - For cnt==0 there is no RECV; done=1 in the cycle after start.
- Per word, with byte_valid held high: 4 RECV cycles + 1 WRITE cycle = 5 cycles minimum.
- mem_we appears in the cycle after the edge that accepted the 4th byte.
- done appears in the cycle after the last WRITE cycle; busy=0 in that same cycle.
- Minimum total: 1 + 5*cnt cycles from start to the done pulse.
- Gaps in byte_valid stall RECV indefinitely; there is no timeout.
- mem_wdata and mem_waddr hold their last value when mem_we=0.

## Test plan
- Two-word load, bytes 93 00 10 00 13 00 00 00, valid held high.
  - mem_we at addr 0 with data 0x00100093.
  - Five cycles later, mem_we at addr 1 with data 0x00000013.
  - done 1 cycle later; err=0.
- Backpressure: same stream with byte_valid low for 3 cycles between every byte.
  - Identical writes and data; no byte is dropped or duplicated.
  - byte_ready=0 in each WRITE cycle.
- word_count=0: done one cycle after start; mem_we never asserts; byte_ready never asserts.
- word_count=65 with DEPTH=64:
  - err=1 from the cycle after start.
  - Exactly 64 writes, addr 0..63; done after the 64th write.
  - err stays 1 until the next accepted start.
- Reset mid-load: assert rst_n=0 after the 2nd byte of word 1.
  - All outputs go to their reset values immediately.
  - A new start with word_count=1 writes its first 4 bytes to addr 0.
- start pulsed while busy: ignored. The load completes with the original count, and no second done pulse occurs.
